ex_muldiv_iter: RTL and testbench
=================================

Name: ex_muldiv_iter

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage.
- Replaces the single-cycle combinational mult/multu/div/divu path with a radix-2 iterative datapath that owns the HI/LO result pair.
- Signals the pipeline to stall while an operation is in flight.
- Can be cancelled when an exception or interrupt is taken.

Parameters:
- WIDTH, 32: operand width; HI and LO are WIDTH bits each; must be at least 4.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- cancel  in  1  abort the operation in flight (exception/interrupt taken).
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  operation in progress (CALC or FIX state).
- stall_req  out  1  combinational: (start & state==IDLE & ~cancel) | busy.
- done  out  1  one-cycle pulse; hi and lo are valid and updated.
- hi  out  WIDTH  product high half / remainder.
- lo  out  WIDTH  product low half / quotient.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, internal accumulators=0, busy=0, done=0, hi=0, lo=0.
- States: IDLE, CALC, FIX.
- IDLE: on a rising edge with start=1 and cancel=0:
  - latch op and the sign flags;
  - latch |a| and |b| for signed ops, raw values for unsigned ops; |x| is the two's-complement negate when the MSB is set;
  - load counter=WIDTH; go to CALC.
- CALC, one iteration per cycle, counter decrements; exit to FIX on the edge where counter goes 1->0, i.e. exactly WIDTH cycles.
- Multiply iteration: shift-add over a 2*WIDTH accumulator; the LSB of the multiplier selects addition of the multiplicand into the upper half, then shift right by 1.
- Divide iteration: restoring divide on a 2*WIDTH remainder/quotient register:
  - shift left 1; trial-subtract the divisor from the upper WIDTH+1 bits;
  - if non-negative, keep the difference and set quotient bit 1; otherwise restore and set 0.
- FIX (one cycle):
  - signed mult: negate the 2*WIDTH product if sign(a)!=sign(b);
  - signed div: quotient negated if signs differ; remainder takes the sign of the dividend;
  - write hi/lo, assert done on the same edge, go to IDLE.
- Latency: start accepted at edge E0 -> done=1 during the cycle after edge E0+WIDTH+1 (WIDTH+2 edges total).
  - busy is high from after E0 until the edge that raises done.
  - done lasts exactly one cycle.
- hi/lo hold their value until the next done or reset; they never change mid-operation.
- Divide by zero (b=0, any div op): no special-case logic; the natural restoring result applies, giving hi=a and lo=all ones (unsigned).
  - For signed div with b=0 the same value is forced: hi=a, lo={WIDTH{1}}. No sign fix-up is applied.
  - Latency is unchanged.
- Signed overflow (a=most-negative, b=-1): lo=most-negative, hi=0, with no trap.
- cancel=1 in CALC or FIX: next edge -> IDLE, no done, hi/lo unchanged, busy=0.
- cancel=1 in IDLE: any start that cycle is ignored.
- start while busy: ignored; no queuing.
- start and cancel together in IDLE: cancel wins.
- Reset asserted mid-operation: immediate return to the reset values; no done is produced.

Test Plan (WIDTH=32):
- mult a=0xFFFFFFFA (-6), b=7 -> after 34 edges, done=1 for one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFD6; busy high for 33 cycles; stall_req high from the start cycle.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then a second start issued while busy is ignored (exactly one done).
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100, b=7 -> lo=14, hi=2.
- divu a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via one mult, start div, pulse cancel at CALC cycle 10 -> busy=0 next edge, no done, hi/lo keep their preloaded values; a fresh start then completes normally.
- Drive rst=0 asynchronously mid-CALC -> busy, done, hi, lo all 0 immediately, before the next clk edge; after rst=1, start accepted on the first edge.

Source files
------------

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter
//   Iterative radix-2 multiply/divide unit for the EX stage. Holds the HI/LO
//   result pair and requests a pipeline stall while an operation is running.
//   One shift-add (multiply) or restoring-subtract (divide) step per cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   start      request a new operation (sampled only in IDLE)
//   op         00 mult, 01 multu, 10 div, 11 divu
//   cancel     abort the operation in flight
//   a, b       rs / rt operands
//   busy       operation in progress (CALC or FIX)
//   stall_req  combinational stall request to the pipeline
//   done       one-cycle pulse when hi/lo have been updated
//   hi, lo     product high/low half, or remainder/quotient
module ex_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               W2       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]    r_acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] r_opnd;       // mult: |multiplicand|; div: |divisor|
    logic             r_is_div;
    logic             r_neg_q;      // result (product/quotient) must be negated
    logic             r_neg_r;      // remainder takes the dividend's sign
    logic             r_dvsr_zero;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_sgn;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [W2-1:0]    w_prod;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    // Add the multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right; the carry becomes the new MSB.
    function automatic logic [W2-1:0] f_mul_step(input logic [W2-1:0] acc,
                                                 input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // Shift left, trial-subtract the divisor from the upper WIDTH+1 bits and
    // shift in the quotient bit. The partial remainder always stays below the
    // divisor, so WIDTH bits are enough to hold it back.
    function automatic logic [W2-1:0] f_div_step(input logic [W2-1:0] acc,
                                                 input logic [WIDTH-1:0] dvsr);
        logic [WIDTH:0]   part;
        logic [WIDTH+1:0] diff;
        part = acc[W2-1:WIDTH-1];
        diff = {1'b0, part} - {2'b00, dvsr};
        if (!diff[WIDTH+1])
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            return {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction

    assign w_sgn   = ~op[0];
    assign w_abs_a = f_abs(a, w_sgn);
    assign w_abs_b = f_abs(b, w_sgn);

    // Sign fix-up of the finished magnitude result. A zero divisor keeps the
    // raw all-ones quotient; the remainder fix-up then reproduces a exactly.
    always_comb begin
        w_prod   = r_acc;
        w_hi_fix = '0;
        w_lo_fix = '0;
        if (!r_is_div) begin
            if (r_neg_q)
                w_prod = -r_acc;
            w_hi_fix = w_prod[W2-1:WIDTH];
            w_lo_fix = w_prod[WIDTH-1:0];
        end else begin
            w_hi_fix = r_neg_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];
            w_lo_fix = (r_neg_q && !r_dvsr_zero) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel)
                    w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (cancel)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_ONE)
                    w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvsr_zero <= 1'b0;
            r_done      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        r_cnt       <= CNT_LOAD;
                        r_is_div    <= op[1];
                        r_neg_q     <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r     <= w_sgn & a[WIDTH-1];
                        r_dvsr_zero <= (b == '0);
                        if (op[1]) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end
                end
                S_CALC: begin
                    if (!cancel) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        r_acc <= r_is_div ? f_div_step(r_acc, r_opnd)
                                          : f_mul_step(r_acc, r_opnd);
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        r_hi   <= w_hi_fix;
                        r_lo   <= w_lo_fix;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign stall_req = (start && (r_state == S_IDLE) && !cancel) || busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
module tb_ex_muldiv_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    ex_muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .cancel    (cancel),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the architectural operands.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: begin
                q = sx * sy;
                return q;
            end
            2'b01: begin
                p = ux * uy;
                return p;
            end
            default: begin
                if (y == 32'd0)
                    return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {r[31:0], q[31:0]};
                end
                p = ux / uy;
                q = longint'(ux % uy);
                return {q[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done. lat counts edges after
    // the accepting edge; busy_cnt counts cycles busy was seen high.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int lat, output int busy_cnt, output logic stall0);
        op = o; a = x; b = y; start = 1'b1;
        #1 stall0 = stall_req;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        rh = hi;
        rl = lo;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'd0)       begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)       begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        #4 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        logic [31:0] rh, rl;
        logic [63:0] e;
        int lat, bc;
        logic s0;
        e = model(2'b00, 32'hFFFF_FFFA, 32'd7);
        run_op(2'b00, 32'hFFFF_FFFA, 32'd7, rh, rl, lat, bc, s0);
        checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", rh); end
        checks++; if (rl !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mult_lo: got %h want ffffffd6", rl); end
        checks++; if ({rh, rl} !== e)       begin errors++; $display("FAIL mult_model: got %h want %h", {rh, rl}, e); end
        checks++; if (lat !== 33)           begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (bc !== 33)            begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
        checks++; if (s0 !== 1'b1)          begin errors++; $display("FAIL mult_stall_at_start: got %b want 1", s0); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL mult_done_width: got %b want 0", done); end
    endtask

    task automatic test_multu_ignore();
        logic [31:0] ph, pl, rh, rl;
        int ndone, first;
        ph = hi; pl = lo;
        rh = 32'd0; rl = 32'd0;
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int n = 0; n < 80; n++) begin
            if (n == 5) begin
                op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
                #1;
                checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL multu_stall_busy: got %b want 1", stall_req); end
            end
            if (n == 6) start = 1'b0;
            if (n == 15) begin
                checks++; if ({hi, lo} !== {ph, pl}) begin errors++; $display("FAIL multu_midop_hold: got %h want %h", {hi, lo}, {ph, pl}); end
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) begin first = n + 1; rh = hi; rl = lo; end
            end
        end
        checks++; if (ndone !== 1)          begin errors++; $display("FAIL multu_done_count: got %0d want 1", ndone); end
        checks++; if (first !== 33)         begin errors++; $display("FAIL multu_latency: got %0d want 33", first); end
        checks++; if (rh !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", rh); end
        checks++; if (rl !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", rl); end
    endtask

    task automatic test_div();
        logic [31:0] rh, rl;
        int lat, bc;
        logic s0;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, rh, rl, lat, bc, s0);
        checks++; if (rl !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", rl); end
        checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", rh); end
        checks++; if (lat !== 33)           begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
        run_op(2'b11, 32'd100, 32'd7, rh, rl, lat, bc, s0);
        checks++; if (rl !== 32'd14)        begin errors++; $display("FAIL divu_lo: got %h want 0000000e", rl); end
        checks++; if (rh !== 32'd2)         begin errors++; $display("FAIL divu_hi: got %h want 00000002", rh); end
    endtask

    task automatic test_div_corner();
        logic [31:0] rh, rl;
        int lat, bc;
        logic s0;
        run_op(2'b11, 32'd100, 32'd0, rh, rl, lat, bc, s0);
        checks++; if (rh !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi: got %h want 00000064", rh); end
        checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", rl); end
        checks++; if (lat !== 33)           begin errors++; $display("FAIL divu0_latency: got %0d want 33", lat); end
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0, rh, rl, lat, bc, s0);
        checks++; if (rh !== 32'hFFFF_FF9C) begin errors++; $display("FAIL div0_hi: got %h want ffffff9c", rh); end
        checks++; if (rl !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", rl); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, lat, bc, s0);
        checks++; if (rl !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", rl); end
        checks++; if (rh !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi: got %h want 00000000", rh); end
    endtask

    task automatic test_cancel();
        logic [31:0] rh, rl;
        logic [63:0] pre, e;
        int lat, bc, nd;
        logic s0;
        pre = model(2'b00, 32'h1234_5678, 32'h0000_0009);
        run_op(2'b00, 32'h1234_5678, 32'h0000_0009, rh, rl, lat, bc, s0);
        checks++; if ({rh, rl} !== pre) begin errors++; $display("FAIL cancel_preload: got %h want %h", {rh, rl}, pre); end
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
        nd = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        checks++; if (nd !== 0)          begin errors++; $display("FAIL cancel_no_done: got %0d want 0", nd); end
        checks++; if ({hi, lo} !== pre)  begin errors++; $display("FAIL cancel_hold: got %h want %h", {hi, lo}, pre); end
        // start and cancel together in IDLE: cancel wins
        op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1; cancel = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_cancel_stall: got %b want 0", stall_req); end
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_cancel_busy: got %b want 0", busy); end
        e = model(2'b11, 32'd1000, 32'd3);
        run_op(2'b11, 32'd1000, 32'd3, rh, rl, lat, bc, s0);
        checks++; if ({rh, rl} !== e) begin errors++; $display("FAIL cancel_restart: got %h want %h", {rh, rl}, e); end
        checks++; if (lat !== 33)     begin errors++; $display("FAIL cancel_restart_lat: got %0d want 33", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rh, rl;
        logic [63:0] e;
        int lat, bc;
        logic s0;
        op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h0000_1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        e = model(2'b10, 32'hFFFF_FC18, 32'd7);
        run_op(2'b10, 32'hFFFF_FC18, 32'd7, rh, rl, lat, bc, s0);
        checks++; if ({rh, rl} !== e) begin errors++; $display("FAIL rstmid_after: got %h want %h", {rh, rl}, e); end
        checks++; if (lat !== 33)     begin errors++; $display("FAIL rstmid_after_lat: got %0d want 33", lat); end
    endtask

    task automatic test_random();
        logic [31:0] x, y, rh, rl;
        logic [1:0]  o;
        logic [63:0] e;
        int lat, bc;
        logic s0;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(1, 15)); end
                3: y = {{24{y[31]}}, y[7:0]};
                default: ;
            endcase
            e = model(o, x, y);
            run_op(o, x, y, rh, rl, lat, bc, s0);
            checks++;
            if ({rh, rl} !== e || lat !== 33) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d want %h lat=33", i, o, x, y, {rh, rl}, lat, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        op = 2'b00;
        a = 32'd0;
        b = 32'd0;
        #2;
        test_reset();
        test_mult();
        test_multu_ignore();
        test_div();
        test_div_corner();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
